regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 98 +++++++++
 tb/tb_regfile_write_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for two masters feeding the 4-entry register file.
// Optional REGFILE_ARB_DROP_R0_EN: acked writes to register 0 never raise regwrite.
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] wr0,
  input  logic [DATA_W-1:0] wd0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] wr1,
  input  logic [DATA_W-1:0] wd1,
  output logic              ack1,
  output logic [ADDR_W-1:0] wr,
  output logic [DATA_W-1:0] wd,
  output logic              regwrite,
  output logic              busy
);

  // Handshake: reqN is held with stable wrN/wdN until ackN is seen high at a
  // rising edge; requests are sampled only in IDLE, and each ack lasts one cycle.
  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state, state_n;
  logic              prio, prio_n;
  logic              regwrite_n, ack0_n, ack1_n;
  logic [ADDR_W-1:0] wr_n;
  logic [DATA_W-1:0] wd_n;
  logic              grant0, grant1, write_en;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      regwrite <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      wr       <= '0;
      wd       <= '0;
    end else begin
      state    <= state_n;
      prio     <= prio_n;
      regwrite <= regwrite_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      wr       <= wr_n;
      wd       <= wd_n;
    end
  end

  always_comb begin
    state_n    = state;
    prio_n     = prio;
    regwrite_n = 1'b0;
    ack0_n     = 1'b0;
    ack1_n     = 1'b0;
    wr_n       = wr;
    wd_n       = wd;
    grant0     = req0 && (!req1 || !prio);
    grant1     = req1 && (!req0 || prio);
    win_addr   = grant1 ? wr1 : wr0;
    win_data   = grant1 ? wd1 : wd0;
`ifdef REGFILE_ARB_DROP_R0_EN
    // Register 0 is hardwired zero; such writes are acked but never issued.
    write_en   = (win_addr != '0);
`else
    write_en   = 1'b1;
`endif
    case (state)
      IDLE: begin
        if (grant0 || grant1) begin
          state_n    = WRITE;
          ack0_n     = grant0;
          ack1_n     = grant1;
          regwrite_n = write_en;
          if (write_en) begin
            wr_n = win_addr;
            wd_n = win_data;
          end
        end
      end
      WRITE: begin
        // Priority moves to the port that lost this round.
        state_n = IDLE;
        prio_n  = ack0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == WRITE);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter: reset, single
// requester, contention, withdrawal, reset mid-write and register-0 writes.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int W      = ADDR_W + DATA_W;

  logic              clock;
  logic              reset_n;
  logic              req0, req1;
  logic [ADDR_W-1:0] wr0, wr1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              ack0, ack1;
  logic [ADDR_W-1:0] wr;
  logic [DATA_W-1:0] wd;
  logic              regwrite;
  logic              busy;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_bad;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req0     (req0),
    .wr0      (wr0),
    .wd0      (wd0),
    .ack0     (ack0),
    .req1     (req1),
    .wr1      (wr1),
    .wd1      (wd1),
    .ack1     (ack1),
    .wr       (wr),
    .wd       (wd),
    .regwrite (regwrite),
    .busy     (busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock; sample 1ns after the edge and score any write on the port.
  task automatic tick();
    @(posedge clock);
    #1;
    if (regwrite === 1'b1) begin
      if (exp_q.size() == 0) check_eq("extra_write", {14'd0, wr, wd}, 32'hDEAD_0000);
      else check_eq("write_data", {14'd0, wr, wd}, {14'd0, exp_q.pop_front()});
    end
  endtask

  task automatic check_outs(input string tag, input logic rw, input logic a0,
                            input logic a1, input logic bz);
    check_eq({tag, "_regwrite"}, {31'd0, regwrite}, {31'd0, rw});
    check_eq({tag, "_ack0"},     {31'd0, ack0},     {31'd0, a0});
    check_eq({tag, "_ack1"},     {31'd0, ack1},     {31'd0, a1});
    check_eq({tag, "_busy"},     {31'd0, busy},     {31'd0, bz});
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_wr", {30'd0, wr}, 32'd0);
    check_eq("reset_wd", {16'd0, wd}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    req0 = 1'b0; wr0 = '0; wd0 = '0;
    req1 = 1'b0; wr1 = '0; wd1 = '0;
    reset_n = 1'b0;
    #1;
    apply_reset();
    #1;
    reset_n = 1'b1;

    // single requester: writes on ticks 1, 3, 5
    req0 = 1'b1; wr0 = 2'd2; wd0 = 16'hBEEF;
    for (int k = 0; k < 3; k++) exp_q.push_back({2'd2, 16'hBEEF});
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_outs($sformatf("single%0d", i), i[0], i[0], 1'b0, i[0]);
    end
    req0 = 1'b0;
    check_eq("single_drain", exp_q.size(), 0);

    // contention from reset: grants 0,1,0,1
    apply_reset();
    req0 = 1'b1; wr0 = 2'd1; wd0 = 16'h1111;
    req1 = 1'b1; wr1 = 2'd3; wd1 = 16'h3333;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({2'd1, 16'h1111});
      exp_q.push_back({2'd3, 16'h3333});
    end
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i[0]) check_outs($sformatf("cont%0d", i), 1'b1, ((i - 1) / 2) % 2 == 0,
                           ((i - 1) / 2) % 2 == 1, 1'b1);
      else      check_outs($sformatf("cont%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
    check_eq("cont_drain", exp_q.size(), 0);

    // withdrawal: req1 pulsed only while port 0 is in WRITE
    req0 = 1'b1; wr0 = 2'd2; wd0 = 16'h2222;
    exp_q.push_back({2'd2, 16'h2222});
    tick();
    check_outs("wd_grant", 1'b1, 1'b1, 1'b0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b1; wr1 = 2'd3; wd1 = 16'h4444;
    tick();
    check_outs("wd_exit", 1'b0, 1'b0, 1'b0, 1'b0);
    req1 = 1'b0;
    tick();
    check_outs("wd_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("wd_drain", exp_q.size(), 0);

    // reset during port-1 WRITE, req1 held, then re-arbitrated
    req1 = 1'b1; wr1 = 2'd3; wd1 = 16'h5555;
    exp_q.push_back({2'd3, 16'h5555});
    tick();
    check_outs("rst_grant", 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    apply_reset();
    #2;
    reset_n = 1'b1;
    exp_q.push_back({2'd3, 16'h5555});
    tick();
    check_outs("rst_regrant", 1'b1, 1'b0, 1'b1, 1'b1);
    req1 = 1'b0;
    tick();
    check_outs("rst_exit", 1'b0, 1'b0, 1'b0, 1'b0);
    // port 1 won last, so port 0 takes the next contended grant
    req0 = 1'b1; wr0 = 2'd1; wd0 = 16'h6666;
    req1 = 1'b1; wr1 = 2'd2; wd1 = 16'h7777;
    exp_q.push_back({2'd1, 16'h6666});
    exp_q.push_back({2'd2, 16'h7777});
    tick();
    check_outs("rr_a", 1'b1, 1'b1, 1'b0, 1'b1);
    req0 = 1'b0;
    tick();
    tick();
    check_outs("rr_b", 1'b1, 1'b0, 1'b1, 1'b1);
    req1 = 1'b0;
    tick();
    check_eq("rr_drain", exp_q.size(), 0);

    // write to register 0
    req0 = 1'b1; wr0 = 2'd0; wd0 = 16'hFFFF;
`ifndef REGFILE_ARB_DROP_R0_EN
    exp_q.push_back({2'd0, 16'hFFFF});
`endif
    tick();
`ifdef REGFILE_ARB_DROP_R0_EN
    check_outs("r0", 1'b0, 1'b1, 1'b0, 1'b1);
`else
    check_outs("r0", 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("r0_wr", {30'd0, wr}, 32'd0);
`endif
    req0 = 1'b0;
    tick();
    check_outs("r0_exit", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
